// File: rtl/model_coil_mc_pkg.sv
// coil_model_pkg: shared constants, ADC flip mask helper and FSM state type for model_coil_mc.
package coil_model_pkg;
  localparam int FRAC = 30;
  localparam int COEF_DEF = 57358;
  localparam int SCALE_DEF = 42089;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  function automatic logic [31:0] adc_flip(input int w);
    return (32'd1 << (w - 1)) - 32'd1;
  endfunction
endpackage

// File: rtl/model_coil_mc_if.sv
// model_coil_mc_if: sample/result bundle of model_coil_mc; ipeak exists only with COIL_PEAK_HOLD_EN.
interface model_coil_mc_if #(
  parameter int NCH = 2,
  parameter int ADC_W = 12,
  parameter int COEF_W = 16
);
  logic                    sample_valid;
  logic                    sample_ready;
  logic [NCH*ADC_W-1:0]    vcap;
  logic [NCH*ADC_W-1:0]    vout;
  logic [NCH-1:0]          pwm;
  logic [NCH*COEF_W-1:0]   coef_lf;
  logic [ADC_W-2:0]        oc_thresh;
  logic [NCH-1:0]          clr;
  logic [NCH*ADC_W-1:0]    iest_coil;
  logic                    iest_valid;
  logic [NCH-1:0]          oc_flag;
  logic [7:0]              drop_cnt;
`ifdef COIL_PEAK_HOLD_EN
  logic [NCH*ADC_W-1:0]    ipeak;
  modport master (output sample_valid, vcap, vout, pwm, coef_lf, oc_thresh, clr,
                  input sample_ready, iest_coil, iest_valid, oc_flag, drop_cnt, ipeak);
  modport slave (input sample_valid, vcap, vout, pwm, coef_lf, oc_thresh, clr,
                 output sample_ready, iest_coil, iest_valid, oc_flag, drop_cnt, ipeak);
`else
  modport master (output sample_valid, vcap, vout, pwm, coef_lf, oc_thresh, clr,
                  input sample_ready, iest_coil, iest_valid, oc_flag, drop_cnt);
  modport slave (input sample_valid, vcap, vout, pwm, coef_lf, oc_thresh, clr,
                 output sample_ready, iest_coil, iest_valid, oc_flag, drop_cnt);
`endif
endinterface

// File: rtl/model_coil_mc_chan_dp.sv
// coil_chan_dp: per-channel deltaV x 1/(L*f) step with direction gate, clip at zero and saturation.
module coil_chan_dp
  import coil_model_pkg::*;
#(
  parameter int ADC_W = 12,
  parameter int COEF_W = 16,
  parameter int ACC_W = 37
) (
  input  logic [ADC_W-1:0]  vcap,
  input  logic [ADC_W-1:0]  vout,
  input  logic              pwm,
  input  logic [COEF_W-1:0] coef,
  input  logic [ACC_W-1:0]  acc,
  output logic              upd,
  output logic [ACC_W-1:0]  acc_nxt
);
  localparam int PW = ADC_W + COEF_W + 2;
  localparam logic [ADC_W-1:0] FLIP = ADC_W'(adc_flip(ADC_W));
  logic [ADC_W-1:0] vcap_c, vout_c;
  logic [ADC_W:0]   dv;
  logic [PW-1:0]    prod;
  logic [ACC_W-1:0] di;
  logic [ACC_W:0]   sum;
  always_comb begin
    vcap_c = vcap ^ FLIP;
    vout_c = vout ^ FLIP;
    dv = (pwm ? {vcap_c[ADC_W-1], vcap_c} : '0) - {vout_c[ADC_W-1], vout_c};
    prod = $signed({{(COEF_W+1){dv[ADC_W]}}, dv}) * $signed({{(ADC_W+1){1'b0}}, coef});
    di = {{(ACC_W-PW){prod[PW-1]}}, prod};
    upd = pwm ? !di[ACC_W-1] : di[ACC_W-1];
    // acc is never negative, so only the positive side can overflow
    sum = {acc[ACC_W-1], acc} + {di[ACC_W-1], di};
    acc_nxt = sum[ACC_W] ? '0 : sum[ACC_W-1] ? {1'b0, {(ACC_W-1){1'b1}}} : sum[ACC_W-1:0];
  end
endmodule

// File: rtl/model_coil_mc.sv
// model_coil_mc: multi-channel coil current estimator with one shared time-multiplexed pipeline.
// Optional per-channel peak hold output ipeak is enabled by COIL_PEAK_HOLD_EN.
module model_coil_mc
  import coil_model_pkg::*;
#(
  parameter int NCH = 2,
  parameter int ADC_W = 12,
  parameter int COEF_W = 16,
  parameter int ACC_W = 37,
  parameter int SCALE = SCALE_DEF
) (
  input logic            clk,
  input logic            reset_n,
  model_coil_mc_if.slave bus
);
  localparam int CW = NCH > 1 ? $clog2(NCH) : 1;
  localparam logic [ADC_W-1:0] FLIP = ADC_W'(adc_flip(ADC_W));
  localparam logic signed [17:0] SC = 18'(SCALE);
  state_t               state_q;
  logic [CW-1:0]        ch_q, s3_ch_q;
  logic                 s3_vld_q, iest_valid_q;
  logic [7:0]           drop_q;
  logic [NCH*ADC_W-1:0] vcap_q, vout_q;
  logic [NCH-1:0]       pwm_q, oc_q, oc_d;
  logic [ACC_W-1:0]     acc_q [NCH], acc_d [NCH];
  logic [ADC_W-1:0]     iest_q [NCH], iest_d [NCH];
  logic                 dp_upd;
  logic [ACC_W-1:0]     dp_nxt;
  logic signed [35:0]   s3_prod;
  logic [ADC_W-1:0]     cur;
`ifdef COIL_PEAK_HOLD_EN
  logic [ADC_W-1:0]     pk_q [NCH], pk_d [NCH];
`endif
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q <= IDLE;
      ch_q <= '0;
      s3_ch_q <= '0;
      s3_vld_q <= 1'b0;
      iest_valid_q <= 1'b0;
      drop_q <= '0;
      vcap_q <= '0;
      vout_q <= '0;
      pwm_q <= '0;
    end else begin
      s3_vld_q <= state_q == RUN;
      s3_ch_q <= ch_q;
      iest_valid_q <= 1'b0;
      if (bus.sample_valid && state_q != IDLE && drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
      case (state_q)
        IDLE: if (bus.sample_valid) begin
          state_q <= RUN;
          ch_q <= '0;
          vcap_q <= bus.vcap;
          vout_q <= bus.vout;
          pwm_q <= bus.pwm;
        end
        RUN: begin
          ch_q <= ch_q + CW'(1);
          if (ch_q == CW'(NCH - 1)) state_q <= DRAIN;
        end
        DRAIN: if (iest_valid_q) state_q <= IDLE;
               else if (!s3_vld_q) iest_valid_q <= 1'b1;
        default: state_q <= IDLE;
      endcase
    end
  coil_chan_dp #(.ADC_W(ADC_W), .COEF_W(COEF_W), .ACC_W(ACC_W)) u_dp (
    .vcap    (vcap_q[ch_q*ADC_W +: ADC_W]),
    .vout    (vout_q[ch_q*ADC_W +: ADC_W]),
    .pwm     (pwm_q[ch_q]),
    .coef    (bus.coef_lf[ch_q*COEF_W +: COEF_W]),
    .acc     (acc_q[ch_q]),
    .upd     (dp_upd),
    .acc_nxt (dp_nxt)
  );
  // clr overrides any writeback landing on the same edge
  always_comb begin
    s3_prod = $signed(acc_q[s3_ch_q][ACC_W-1 -: 18]) * SC;
    cur = ADC_W'(s3_prod >>> (36 - ADC_W));
    for (int k = 0; k < NCH; k++) begin
      acc_d[k] = bus.clr[k] ? '0 : state_q == RUN && ch_q == CW'(k) && dp_upd ? dp_nxt : acc_q[k];
      iest_d[k] = bus.clr[k] ? FLIP : s3_vld_q && s3_ch_q == CW'(k) ? cur ^ FLIP : iest_q[k];
      oc_d[k] = !bus.clr[k] && (oc_q[k] || (s3_vld_q && s3_ch_q == CW'(k) &&
                $signed(cur) > $signed({1'b0, bus.oc_thresh})));
`ifdef COIL_PEAK_HOLD_EN
      pk_d[k] = bus.clr[k] ? FLIP : s3_vld_q && s3_ch_q == CW'(k) &&
                $signed(cur) > $signed(pk_q[k] ^ FLIP) ? cur ^ FLIP : pk_q[k];
`endif
    end
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      oc_q <= '0;
      for (int k = 0; k < NCH; k++) begin
        acc_q[k] <= '0;
        iest_q[k] <= FLIP;
`ifdef COIL_PEAK_HOLD_EN
        pk_q[k] <= FLIP;
`endif
      end
    end else begin
      oc_q <= oc_d;
      acc_q <= acc_d;
      iest_q <= iest_d;
`ifdef COIL_PEAK_HOLD_EN
      pk_q <= pk_d;
`endif
    end
  assign bus.sample_ready = state_q == IDLE;
  assign bus.iest_valid = iest_valid_q;
  assign bus.oc_flag = oc_q;
  assign bus.drop_cnt = drop_q;
  for (genvar g = 0; g < NCH; g++) begin : g_out
    assign bus.iest_coil[g*ADC_W +: ADC_W] = iest_q[g];
`ifdef COIL_PEAK_HOLD_EN
    assign bus.ipeak[g*ADC_W +: ADC_W] = pk_q[g];
`endif
  end
endmodule
